// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchroniser and counted-stability filter
// producing a clean level plus press, release and long-press pulses.
`timescale 1ns/1ps
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_hold
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] H_SAT  = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t state, state_n;

  logic          s1, s2;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic          level_n, rise_n, fall_n, hold_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      state     <= RELEASED;
      dcnt      <= '0;
      hcnt      <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
      btn_hold  <= 1'b0;
    end else begin
      s1        <= btn_raw;
      s2        <= s1;
      state     <= state_n;
      dcnt      <= dcnt_n;
      hcnt      <= hcnt_n;
      btn_level <= level_n;
      btn_rise  <= rise_n;
      btn_fall  <= fall_n;
      btn_hold  <= hold_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RELEASED: begin
        if (s2) state_n = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!s2)
          state_n = RELEASED;
        else if (dcnt == D_LAST)
          state_n = PRESSED;
      end
      PRESSED: begin
        if (!s2) state_n = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (s2)
          state_n = PRESSED;
        else if (dcnt == D_LAST)
          state_n = RELEASED;
      end
      default: state_n = RELEASED;
    endcase
  end

  // hcnt survives a rejected release bounce so a fired hold stays spent
  always_comb begin
    dcnt_n  = dcnt;
    hcnt_n  = hcnt;
    level_n = btn_level;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    hold_n  = 1'b0;
    unique case (state)
      RELEASED: begin
        if (s2) dcnt_n = '0;
      end
      PRESS_WAIT: begin
        if (s2) begin
          if (dcnt == D_LAST) begin
            level_n = 1'b1;
            rise_n  = 1'b1;
            hcnt_n  = '0;
          end else begin
            dcnt_n = dcnt + 1'b1;
          end
        end
      end
      PRESSED: begin
        if (!s2) begin
          dcnt_n = '0;
        end else if (hcnt == H_LAST) begin
          hold_n = 1'b1;
          hcnt_n = H_SAT;
        end else if (hcnt < H_LAST) begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (!s2) begin
          if (dcnt == D_LAST) begin
            level_n = 1'b0;
            fall_n  = 1'b1;
          end else begin
            dcnt_n = dcnt + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: scoreboarded pulse timing plus inline level and
// reset checks for the debouncer with D=4, H=10.
`timescale 1ns/1ps
module tb_button_debouncer;

  localparam int D = 4;
  localparam int H = 10;
  localparam int LAT = D + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_raw = 1'b0;
  logic level, rise, fall, hold;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t   sb[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  string names[3] = '{"rise", "fall", "hold"};
  logic [2:0] obs;

  button_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .btn_raw(btn_raw),
    .btn_level(level),
    .btn_rise(rise),
    .btn_fall(fall),
    .btn_hold(hold)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor: every observed pulse must match the scoreboard head
  always @(negedge clk) begin
    obs = {hold, fall, rise};
    while (sb.size() > 0 && sb[0].at < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_%s: no pulse by edge %0d, required at edge %0d",
               names[sb[0].kind], cyc, sb[0].at);
      void'(sb.pop_front());
    end
    for (int b = 0; b < 3; b++) begin
      if (obs[b] === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_%s: pulse at edge %0d, required none",
                   names[b], cyc);
        end else begin
          if (sb[0].kind != b || sb[0].at != cyc) begin
            n_bad++;
            $display("FAIL pulse_%s: got %s at edge %0d, required %s at edge %0d",
                     names[b], names[b], cyc, names[sb[0].kind], sb[0].at);
          end
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    step(3);
    n_cmp++;
    if ({level, rise, fall, hold} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b required 0000",
               {level, rise, fall, hold});
    end
    btn_raw = 1'b1;
    step(8);
    n_cmp++;
    if ({level, rise, fall, hold} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_held_press: got %b required 0000",
               {level, rise, fall, hold});
    end
    btn_raw = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(10);
  endtask

  task automatic test_clean_press();
    int k;
    k = cyc + 1;
    btn_raw = 1'b1;
    push_ev(0, k + LAT);
    step(LAT);
    n_cmp++;
    if (level !== 1'b0) begin
      n_bad++;
      $display("FAIL clean_level_early: got %b required 0", level);
    end
    step(1);
    n_cmp++;
    if (level !== 1'b1 || rise !== 1'b1) begin
      n_bad++;
      $display("FAIL clean_accept: got level=%b rise=%b required 1 1",
               level, rise);
    end
    step(1);
    n_cmp++;
    if (level !== 1'b1 || rise !== 1'b0) begin
      n_bad++;
      $display("FAIL clean_after: got level=%b rise=%b required 1 0",
               level, rise);
    end
    k = cyc + 1;
    btn_raw = 1'b0;
    push_ev(1, k + LAT);
    step(LAT);
    n_cmp++;
    if (level !== 1'b1) begin
      n_bad++;
      $display("FAIL clean_release_early: got %b required 1", level);
    end
    step(1);
    n_cmp++;
    if (level !== 1'b0) begin
      n_bad++;
      $display("FAIL clean_release: got %b required 0", level);
    end
    step(6);
  endtask

  task automatic test_bounce();
    logic pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int k;
    for (int i = 0; i < 6; i++) begin
      btn_raw = pat[i];
      step(1);
    end
    k = cyc + 1;
    btn_raw = 1'b1;
    push_ev(0, k + LAT);
    step(12);
    n_cmp++;
    if (level !== 1'b1) begin
      n_bad++;
      $display("FAIL bounce_level: got %b required 1", level);
    end
    k = cyc + 1;
    btn_raw = 1'b0;
    push_ev(1, k + LAT);
    step(12);
  endtask

  task automatic test_long_press();
    int k;
    k = cyc + 1;
    btn_raw = 1'b1;
    push_ev(0, k + LAT);
    push_ev(2, k + LAT + H);
    step(30);
    n_cmp++;
    if (level !== 1'b1) begin
      n_bad++;
      $display("FAIL long_level: got %b required 1", level);
    end
    k = cyc + 1;
    btn_raw = 1'b0;
    push_ev(1, k + LAT);
    step(12);
    n_cmp++;
    if (level !== 1'b0) begin
      n_bad++;
      $display("FAIL long_release: got %b required 0", level);
    end
  endtask

  task automatic test_short_press();
    int k;
    k = cyc + 1;
    btn_raw = 1'b1;
    push_ev(0, k + LAT);
    step(12);
    k = cyc + 1;
    btn_raw = 1'b0;
    push_ev(1, k + LAT);
    step(20);
  endtask

  task automatic test_release_bounce();
    int k;
    k = cyc + 1;
    btn_raw = 1'b1;
    push_ev(0, k + LAT);
    step(8);
    btn_raw = 1'b0;
    step(2);
    btn_raw = 1'b1;
    // three hold-counting cycles are lost to the rejected release
    push_ev(2, k + LAT + H + 3);
    step(6);
    n_cmp++;
    if (level !== 1'b1) begin
      n_bad++;
      $display("FAIL rb_level_1: got %b required 1", level);
    end
    step(15);
    btn_raw = 1'b0;
    step(2);
    btn_raw = 1'b1;
    step(6);
    n_cmp++;
    if (level !== 1'b1) begin
      n_bad++;
      $display("FAIL rb_level_2: got %b required 1", level);
    end
    step(15);
    k = cyc + 1;
    btn_raw = 1'b0;
    push_ev(1, k + LAT);
    step(13);
    n_cmp++;
    if (level !== 1'b0) begin
      n_bad++;
      $display("FAIL rb_release: got %b required 0", level);
    end
  endtask

  task automatic test_async_reset();
    int k;
    k = cyc + 1;
    btn_raw = 1'b1;
    step(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({level, rise, fall, hold} !== 4'b0000) begin
      n_bad++;
      $display("FAIL arst_wait: got %b required 0000",
               {level, rise, fall, hold});
    end
    step(3);
    rst_n = 1'b1;
    k = cyc + 1;
    push_ev(0, k + LAT);
    step(LAT + 3);
    n_cmp++;
    if (level !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_reaccept: got %b required 1", level);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({level, rise, fall, hold} !== 4'b0000) begin
      n_bad++;
      $display("FAIL arst_pressed: got %b required 0000",
               {level, rise, fall, hold});
    end
    step(3);
    rst_n = 1'b1;
    k = cyc + 1;
    push_ev(0, k + LAT);
    push_ev(2, k + LAT + H);
    step(20);
    k = cyc + 1;
    btn_raw = 1'b0;
    push_ev(1, k + LAT);
    step(12);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_short_press();
    test_release_bounce();
    test_async_reset();
    step(2);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d pulses outstanding, required 0",
               sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
